// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
//
// Runtime-programmable clock-enable / phase-strobe generator running on the
// fast PLL output clock. It qualifies the (asynchronous) PLL lock signal,
// produces a synchronous system reset for downstream logic, and drives
// CHANNELS independent divided-rate enables (ce) with a matching phase-offset
// strobe (ce_p). All channels restart phase-aligned every time RUN is entered.
//
// Ports
//   clk        in   fast PLL clock, all logic on the rising edge
//   reset      in   asynchronous active-high reset (released through clk)
//   pll_lock   in   raw PLL lock, asynchronous to clk
//   cfg_valid  in   configuration write request
//   cfg_ready  out  configuration write accepted when cfg_valid & cfg_ready
//   cfg_ch     in   target channel (out-of-range channels are accepted, dropped)
//   cfg_div    in   divisor N (0 behaves as 1)
//   cfg_phase  in   strobe offset in clk cycles (clamped to N-1)
//   ce         out  one-cycle enable per channel, period N
//   ce_p       out  one-cycle phase strobe per channel, period N
//   ready      out  high while in RUN
//   sys_reset  out  synchronous active-high downstream reset, = !ready
//   dbg_state  out  current FSM state (HOLD=0, WAIT=1, RUN=2)
//
// Config handshake: a write transfers on a rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready is low in HOLD and while the addressed
// channel still holds an unapplied update; the master keeps cfg_valid and the
// payload stable until the transfer happens. cfg_ready may depend
// combinationally on cfg_ch.
// -----------------------------------------------------------------------------
module clk_enable_gen #(
  parameter int CHANNELS      = 3,
  parameter int DIV_W         = 8,
  parameter int LOCK_CYCLES   = 1024,
  parameter int DEFAULT_DIV   = 4,
  parameter int DEFAULT_PHASE = 1,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_lock,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_phase,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] ce_p,
  output logic                ready,
  output logic                sys_reset,
  output logic [1:0]          dbg_state
);

  localparam int LCW = $clog2(LOCK_CYCLES);

  // Reset-time channel configuration, with the same normalisation a write gets.
  localparam logic [DIV_W-1:0] DEF_DIV =
    (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_PHASE =
    (DEFAULT_PHASE >= int'(DEF_DIV)) ? (DEF_DIV - DIV_W'(1)) : DIV_W'(DEFAULT_PHASE);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] p,
                                                   input logic [DIV_W-1:0] d);
    return (p >= d) ? (d - DIV_W'(1)) : p;
  endfunction

  // ---------------------------------------------------------------------------
  // Reset release stage: assertion is immediate, release waits for one clk
  // edge so the rest of the block leaves reset cleanly on a clock boundary.
  // ---------------------------------------------------------------------------
  logic rst_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_q <= 1'b1;
    else       rst_q <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for the raw PLL lock. Only lock_s_q is used below.
  // ---------------------------------------------------------------------------
  logic lock_meta_q;
  logic lock_s_q;

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock qualification FSM with registered ready / sys_reset.
  // RUN is entered on the LOCK_CYCLES-th consecutive edge that sees lock_s=1.
  // ---------------------------------------------------------------------------
  state_t         state_q;
  logic [LCW-1:0] lock_cnt_q;
  logic           ready_q;
  logic           sys_reset_q;

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state_q     <= ST_HOLD;
      lock_cnt_q  <= '0;
      ready_q     <= 1'b0;
      sys_reset_q <= 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_q    <= ST_WAIT;
          lock_cnt_q <= '0;
        end
        ST_WAIT: begin
          if (lock_s_q) begin
            if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
              state_q     <= ST_RUN;
              ready_q     <= 1'b1;
              sys_reset_q <= 1'b0;
              lock_cnt_q  <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_q + LCW'(1);
            end
          end else begin
            // Any dropout restarts qualification from zero.
            lock_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_q     <= ST_WAIT;
            ready_q     <= 1'b0;
            sys_reset_q <= 1'b1;
            lock_cnt_q  <= '0;
          end
        end
        default: begin
          state_q     <= ST_HOLD;
          ready_q     <= 1'b0;
          sys_reset_q <= 1'b1;
          lock_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign sys_reset = sys_reset_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Configuration handshake
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0]    pend_q;
  logic [(1<<CH_W)-1:0]   pend_pad;
  logic                   ch_ok;
  logic                   cfg_accept;

  // Zero-padded view so any cfg_ch value indexes safely; out-of-range
  // channels read as "not pending" and are therefore always ready.
  always_comb begin
    pend_pad                = '0;
    pend_pad[CHANNELS-1:0]  = pend_q;
  end

  assign ch_ok      = (32'(cfg_ch) < 32'(CHANNELS));
  assign cfg_ready  = (state_q != ST_HOLD) && !pend_pad[cfg_ch];
  assign cfg_accept = cfg_valid && cfg_ready && ch_ok;

  // ---------------------------------------------------------------------------
  // Channel counters and configuration registers
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q    [CHANNELS];
  logic [DIV_W-1:0] phase_q  [CHANNELS];
  logic [DIV_W-1:0] cnt_q    [CHANNELS];
  logic [DIV_W-1:0] pdiv_q   [CHANNELS];
  logic [DIV_W-1:0] pphase_q [CHANNELS];

  logic                run;
  logic                stay_run;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] apply;
  logic [CHANNELS-1:0] wr_sel;

  assign run      = (state_q == ST_RUN);
  // Counters only advance on edges where RUN continues; entering or leaving
  // RUN leaves every counter at zero, which gives the phase alignment.
  assign stay_run = run && lock_s_q;

  always_comb begin
    wrap   = '0;
    apply  = '0;
    wr_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wrap[i]   = (cnt_q[i] == (div_q[i] - DIV_W'(1)));
      // In RUN an update waits for the end of the current period so no
      // shortened period is ever produced; otherwise it lands at once.
      apply[i]  = pend_q[i] && (!run || wrap[i]);
      wr_sel[i] = cfg_accept && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i]    <= DEF_DIV;
        phase_q[i]  <= DEF_PHASE;
        cnt_q[i]    <= '0;
        pdiv_q[i]   <= DEF_DIV;
        pphase_q[i] <= DEF_PHASE;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (apply[i]) begin
          div_q[i]   <= pdiv_q[i];
          phase_q[i] <= pphase_q[i];
        end

        // A write needs pend=0 and an apply needs pend=1, so they never
        // collide on the same channel in the same cycle.
        if (wr_sel[i]) begin
          pdiv_q[i]   <= eff_div(cfg_div);
          pphase_q[i] <= clamp_phase(cfg_phase, eff_div(cfg_div));
          pend_q[i]   <= 1'b1;
        end else if (apply[i]) begin
          pend_q[i] <= 1'b0;
        end

        if (stay_run && !wrap[i]) cnt_q[i] <= cnt_q[i] + DIV_W'(1);
        else                      cnt_q[i] <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded straight from registered counters, so they are clean
  // one-cycle pulses with no wrap glitches.
  // ---------------------------------------------------------------------------
  always_comb begin
    ce   = '0;
    ce_p = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ce[i]   = run && (cnt_q[i] == '0);
      ce_p[i] = run && (cnt_q[i] == phase_q[i]);
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_enable_gen
//
// Self-checking bench for clk_enable_gen. A reference model advances on every
// clock edge (or reset assertion) and pushes the expected output picture into
// exp_q; an independent monitor pops one entry per clock on the falling edge
// and compares it with the DUT. Directed scenarios add latency and
// asynchronous-reset checks; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_clk_enable_gen;

  localparam int CH    = 3;
  localparam int DW    = 8;
  localparam int L     = 32;
  localparam int CHW   = 2;
  localparam int EW    = 1 + CH + 1 + CH + CH;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  logic           pll_lock  = 1'b1;
  logic           cfg_valid = 1'b0;
  logic [CHW-1:0] cfg_ch    = '0;
  logic [DW-1:0]  cfg_div   = '0;
  logic [DW-1:0]  cfg_phase = '0;
  logic           cfg_ready;
  logic [CH-1:0]  ce;
  logic [CH-1:0]  ce_p;
  logic           ready;
  logic           sys_reset;
  logic [1:0]     dbg_state;

  clk_enable_gen #(
    .CHANNELS      (CH),
    .DIV_W         (DW),
    .LOCK_CYCLES   (L),
    .DEFAULT_DIV   (4),
    .DEFAULT_PHASE (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .ce        (ce),
    .ce_p      (ce_p),
    .ready     (ready),
    .sys_reset (sys_reset),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: channels described by "cycles since the current period
  // train started" plus modular arithmetic; lock qualification described as a
  // streak of synchronised lock samples.
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];

  bit m_rel, m_hold, m_run, m_s1, m_s2;
  int m_streak;
  int m_div[CH], m_ph[CH], m_age[CH], m_pdiv[CH], m_pph[CH];
  bit m_pend[CH];

  function automatic logic [EW-1:0] model_picture();
    logic [CH-1:0] mask, e_ce, e_cp;
    mask = '0;
    e_ce = '0;
    e_cp = '0;
    for (int c = 0; c < CH; c++) begin
      mask[c] = !m_hold && !m_pend[c];
      e_ce[c] = m_run && ((m_age[c] % m_div[c]) == 0);
      e_cp[c] = m_run && ((m_age[c] % m_div[c]) == m_ph[c]);
    end
    return {m_hold, mask, m_run, e_ce, e_cp};
  endfunction

  task automatic model_reset();
    m_rel = 0; m_hold = 1; m_run = 0; m_s1 = 0; m_s2 = 0; m_streak = 0;
    for (int c = 0; c < CH; c++) begin
      m_div[c] = 4; m_ph[c] = 1; m_age[c] = 0; m_pend[c] = 0;
      m_pdiv[c] = 4; m_pph[c] = 1;
    end
  endtask

  task automatic model_step();
    bit ls, was_run, acc;
    bit applied[CH];
    int ch_i, d, p;
    ls      = m_s2;
    was_run = m_run;
    ch_i    = int'(cfg_ch);
    acc     = 0;
    if (cfg_valid && !m_hold && ch_i < CH) acc = !m_pend[ch_i];
    for (int c = 0; c < CH; c++) begin
      applied[c] = 0;
      if (m_pend[c] && (!was_run || ((m_age[c] + 1) % m_div[c]) == 0)) begin
        m_div[c] = m_pdiv[c]; m_ph[c] = m_pph[c]; m_pend[c] = 0; applied[c] = 1;
      end
    end
    if (m_hold) m_hold = 0;
    else if (!m_run) begin
      if (ls) begin
        m_streak++;
        if (m_streak == L) begin m_run = 1; m_streak = 0; end
      end else m_streak = 0;
    end else if (!ls) m_run = 0;
    for (int c = 0; c < CH; c++)
      if (!m_run || !was_run || applied[c]) m_age[c] = 0;
      else m_age[c]++;
    m_s2 = m_s1;
    m_s1 = pll_lock;
    if (acc) begin
      d = (cfg_div == 0) ? 1 : int'(cfg_div);
      p = (int'(cfg_phase) >= d) ? d - 1 : int'(cfg_phase);
      m_pdiv[ch_i] = d; m_pph[ch_i] = p; m_pend[ch_i] = 1;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back(model_picture());
    end else begin
      if (!m_rel) m_rel = 1;   // the edge that releases the internal reset
      else model_step();
      exp_q.push_back(model_picture());
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [CH-1:0] mask;
    logic          e_rdy_cfg;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("queue_empty", 32'd1, 32'd0);
      end else begin
        e    = exp_q.pop_front();
        mask = e[EW-2 -: CH];
        if (int'(cfg_ch) >= CH) e_rdy_cfg = !e[EW-1];
        else                    e_rdy_cfg = mask[cfg_ch];
        chk("ready_sysreset", {30'd0, ready, sys_reset}, {30'd0, e[2*CH], !e[2*CH]});
        chk("ce", 32'(ce), 32'(e[2*CH-1 -: CH]));
        chk("ce_p", 32'(ce_p), 32'(e[CH-1:0]));
        chk("cfg_ready", 32'(cfg_ready), 32'(e_rdy_cfg));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int d, input int p);
    int  waited;
    bit  done, seen;
    waited = 0;
    done   = 0;
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_div   = DW'(d);
    cfg_phase = DW'(p);
    while (!done) begin
      @(negedge clk);
      seen = cfg_ready;
      tick();
      if (seen) done = 1;
      else if (++waited > 100) begin
        chk("cfg_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    cfg_valid = 1'b0;
  endtask

  // Called 1 time unit after an edge; releases reset between edges.
  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_ready(input bit level, input int limit, output int n);
    n = 0;
    while (ready !== level && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic lock_blip();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    bit did_rst;
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (3) tick();
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_sysreset", 32'(sys_reset), 32'd1);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd0);

    // Lock held high from the start: RUN after release stage + sync + count.
    release_reset();
    n = 0;
    do begin tick(); n++; end while (!ready && n < 4 * L);
    chk("lock_latency", n, L + 3);
    chk("ce_aligned", 32'(ce), 32'h7);

    // Reprogram ch1 mid-period, then ch2 to divide-by-1, ch0 with clamp.
    repeat (2) tick();
    cfg_write(1, 6, 3);
    repeat (20) tick();
    cfg_write(2, 0, 9);
    cfg_write(0, 5, 7);
    repeat (20) tick();
    // Back-to-back writes to one channel: the second waits for the apply.
    cfg_write(1, 3, 2);
    cfg_write(1, 7, 6);
    repeat (25) tick();

    // One-cycle lock dropout in RUN.
    lock_blip();
    n = 1;
    while (ready && n < 20) begin tick(); n++; end
    chk("drop_latency", n, 3);
    chk("drop_ce", 32'(ce), 32'd0);
    chk("drop_ce_p", 32'(ce_p), 32'd0);
    wait_ready(1'b1, 4 * L, n);
    chk("requal_latency", n, L);
    chk("requal_ce", 32'(ce), 32'h7);
    repeat (15) tick();

    // Lock glitch halfway through qualification restarts the count.
    lock_blip();
    wait_ready(1'b0, 20, n);
    n = 0;
    repeat (L / 2) begin tick(); n++; end
    lock_blip();
    n++;
    while (!ready && n < 4 * L) begin tick(); n++; end
    chk("glitch_requal", n, L + L / 2 + 3);
    repeat (10) tick();

    // Asynchronous reset between edges in RUN, with an update pending.
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd9; cfg_phase = 8'd2;
    tick();
    cfg_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_sysreset", 32'(sys_reset), 32'd1);
    chk("async_ce", 32'(ce), 32'd0);
    chk("async_ce_p", 32'(ce_p), 32'd0);
    chk("async_cfg_ready", 32'(cfg_ready), 32'd0);
    repeat (2) tick();
    release_reset();
    cfg_write(3, 9, 2);   // out-of-range channel: accepted, no effect
    wait_ready(1'b1, 4 * L, n);
    chk("post_reset_run", 32'(ready), 32'd1);
    repeat (30) tick();

    // Randomized traffic: writes, lock dropouts, one async reset.
    did_rst = 0;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pll_lock = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        pll_lock = 1'b1;
      end else if (r < 40) begin
        cfg_write($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 11));
      end else if (r == 99 && it > 200 && !did_rst) begin
        did_rst = 1;
        #3;
        reset = 1'b1;
        repeat (2) tick();
        release_reset();
      end else begin
        repeat ($urandom_range(1, 4)) tick();
      end
    end
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
